lsm_sequencer: RTL and testbench
================================

// Module: lsm_sequencer
// PURPOSE
//  Memory-stage initiator for data_mem: turns one load/store opcode into 1..9 word/half/byte
//  transfers on the data_mem port (mem_write_en/opCode/mem_addr/mem_data_in, 1-cycle read latency).
//  Sequences LDM/STM/PUSH/POP one register per cycle, stalls the pipeline, and returns load data and
//  base/SP writeback to the register file. Sits between EX/MEM pipeline regs and data_mem.
// PARAMETERS
//  ADDR_STEP  1   address increment per word; data_mem is word-indexed per byte lane
//  AW         32  address width
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   async active-high reset
//  start         in   1   mem op valid this cycle (ignored unless IDLE)
//  opcode_in     in   7   instr[15:9]
//  reg_list      in   9   [7:0]=R0..R7; [8]=LR (PUSH) / PC (POP)
//  rn_idx        in   3   base reg index for LDM/STM
//  base_addr     in   AW  single-op addr, or Rn/SP value for multiple ops
//  store_data    in   32  single-op store data
//  rf_rd_idx     out  4   reg-file read index during STM/PUSH (comb read)
//  rf_rd_data    in   32  reg-file data for rf_rd_idx
//  mem_write_en  out  1   to data_mem
//  mem_opcode    out  7   to data_mem opCode (latched opcode_in)
//  mem_addr      out  AW  to data_mem
//  mem_wdata     out  32  to data_mem mem_data_in
//  mem_rdata     in   32  from data_mem mem_data_out (valid cycle after address)
//  wb_en/wb_idx/wb_data  out 1/4/32  load result writeback
//  base_wb_en/base_wb_data out 1/AW  Rn/SP writeback
//  stall         out  1   hold upstream; more transfers pending
//  done          out  1   pulse on final issued transfer
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; pending wb dropped. Reset mid-sequence aborts, no further issue.
//  States IDLE, MULTI. Mem port is comb from current transfer: IDLE+start uses inputs directly
//   (transfer 0 issued in start cycle); MULTI uses latched opcode, addr counter, remaining list.
//  Single ops (reg/imm/SP/literal): one issue in start cycle, done=1, stay IDLE; stores put
//   store_data on mem_wdata; loads: wb_en=1 next cycle, wb_data=mem_rdata (data_mem sizes/extends).
//  N = popcount(list) (bit8 counted per CONFIG). Order: lowest reg index -> lowest address.
//   STM/LDM: addr0=base, ascending; base_wb=base+N*STEP. PUSH: addr0=SP-N*STEP; base_wb=addr0.
//   POP: addr0=SP, ascending; base_wb=SP+N*STEP. PUSH bit8 reads R14.
//  Issue k at cycle k (0..N-1); state MULTI while k<N-1; stall=1 in cycles 0..N-2 (comb in cycle 0);
//   done and base_wb_en=1 in cycle N-1. Loads: wb_en/wb_idx for transfer k in cycle k+1.
//  LDM with Rn in list: base_wb suppressed, loaded value wins. N=0: no transfer, done=1, no wb.
//  Address arithmetic mod 2^AW (wrap silent). start while MULTI ignored.
//  Unknown opcode with start: no transfer, done=1, all wb 0.
// CONFIGURATION
//  LSM_POP_PC_EN defined: POP bit8 counted, highest address loads PC: outputs pc_load_en/pc_load_data
//   pulse in cycle N (wb_en stays 0 for it). Undefined: bit8 on POP ignored, no pc_load ports.
// TESTING
//  STR imm, base=5, data=0xDEADBEEF -> cycle0 mem_write_en=1, addr=5, wdata=0xDEADBEEF, done=1, stall=0
//  LDR after it, base=5 -> cycle1 wb_en=1, wb_data=0xDEADBEEF
//  PUSH {R0,R1,LR}, SP=100 -> writes addr 97,98,99 cycles 0-2; stall 1,1,0; base_wb=97 in cycle 2
//  POP {R0,R1}, SP=97 -> reads 97,98; wb R0 cycle1, R1 cycle2; base_wb=99 cycle1
//  LDM R2!,{R2,R3} base=40 -> wb R2,R3; base_wb_en never 1; rst in cycle1 -> all outputs 0, IDLE
//  Empty list STM -> no mem_write_en, done=1 cycle0; POP {PC} with LSM_POP_PC_EN -> pc_load at addr SP

Source files
------------

// File: rtl/lsm_sequencer_if.sv
// Pipeline-side and data_mem-side signal bundle for lsm_sequencer.
// LSM_POP_PC_EN adds the pc_load pair used when POP may load the PC.
interface lsm_sequencer_if #(
  parameter int unsigned AW = 32
);
  logic          start;
  logic [6:0]    opcode_in;
  logic [8:0]    reg_list;
  logic [2:0]    rn_idx;
  logic [AW-1:0] base_addr;
  logic [31:0]   store_data;
  logic [3:0]    rf_rd_idx;
  logic [31:0]   rf_rd_data;
  logic          mem_write_en;
  logic [6:0]    mem_opcode;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          wb_en;
  logic [3:0]    wb_idx;
  logic [31:0]   wb_data;
  logic          base_wb_en;
  logic [AW-1:0] base_wb_data;
  logic          stall;
  logic          done;
`ifdef LSM_POP_PC_EN
  logic          pc_load_en;
  logic [31:0]   pc_load_data;
`endif

  modport master (
    input  start, opcode_in, reg_list, rn_idx, base_addr, store_data, rf_rd_data, mem_rdata,
    output rf_rd_idx, mem_write_en, mem_opcode, mem_addr, mem_wdata,
    output wb_en, wb_idx, wb_data, base_wb_en, base_wb_data, stall, done
`ifdef LSM_POP_PC_EN
    , output pc_load_en, pc_load_data
`endif
  );

  modport slave (
    output start, opcode_in, reg_list, rn_idx, base_addr, store_data, rf_rd_data, mem_rdata,
    input  rf_rd_idx, mem_write_en, mem_opcode, mem_addr, mem_wdata,
    input  wb_en, wb_idx, wb_data, base_wb_en, base_wb_data, stall, done
`ifdef LSM_POP_PC_EN
    , input pc_load_en, pc_load_data
`endif
  );
endinterface

// File: rtl/lsm_sequencer.sv
// Memory-stage load/store sequencer: single ops plus LDM/STM/PUSH/POP, one transfer per cycle.
// Define LSM_POP_PC_EN to let POP bit 8 load the PC through pc_load_en/pc_load_data.
module lsm_sequencer #(
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned AW        = 32
) (
  input logic             clk,
  input logic             rst,
  lsm_sequencer_if.master bus
);
  typedef enum logic {StIdle, StMulti} state_e;
  typedef enum logic [2:0] {OpNone, OpBad, OpLoad, OpStore, OpStm, OpLdm, OpPush, OpPop} op_e;

  // Thumb-1 instr[15:9] classes; Rn/Rd bits inside the field are don't-care here.
  function automatic op_e decode(input logic [6:0] op);
    op_e res;
    casez (op)
      7'b0101000, 7'b0101001, 7'b0101010: res = OpStore;
      7'b0101011, 7'b01011??, 7'b01001??: res = OpLoad;
      7'b011?0??, 7'b10000??, 7'b10010??: res = OpStore;
      7'b011?1??, 7'b10001??, 7'b10011??: res = OpLoad;
      7'b1011010:                         res = OpPush;
      7'b1011110:                         res = OpPop;
      7'b11000??:                         res = OpStm;
      7'b11001??:                         res = OpLdm;
      default:                            res = OpBad;
    endcase
    return res;
  endfunction

  state_e        r_state, w_state_d;
  op_e           r_op, w_op_d, w_op;
  logic [6:0]    r_opcode, w_opcode_d;
  logic [8:0]    r_list, w_list_d;
  logic [AW-1:0] r_addr, w_addr_d;
  logic [AW-1:0] r_base_wb, w_base_wb_d;
  logic          r_sup, w_sup_d;
  logic          r_wb_en, w_wb_en_d;
  logic [3:0]    r_wb_idx, w_wb_idx_d;
`ifdef LSM_POP_PC_EN
  logic          r_pc_en, w_pc_en_d;
`endif

  logic          w_idle, w_start, w_multi, w_store_m, w_load_m, w_xfer, w_last, w_sup;
  logic [8:0]    w_in_list, w_list, w_low, w_rest;
  logic [3:0]    w_cnt, w_bit, w_idx;
  logic [AW-1:0] w_step_n, w_addr0, w_addr, w_bwb;

  always_comb begin
    w_start = bus.start & ~rst;
    w_idle  = (r_state == StIdle);
    w_op    = OpNone;
    if (!w_idle)      w_op = r_op;
    else if (w_start) w_op = decode(bus.opcode_in);

    w_in_list = '0;
    case (w_op)
      OpStm, OpLdm: w_in_list = {1'b0, bus.reg_list[7:0]};
      OpPush:       w_in_list = bus.reg_list;
`ifdef LSM_POP_PC_EN
      OpPop:        w_in_list = bus.reg_list;
`else
      OpPop:        w_in_list = {1'b0, bus.reg_list[7:0]};
`endif
      default:      w_in_list = '0;
    endcase

    w_multi   = (w_op == OpStm) || (w_op == OpLdm) || (w_op == OpPush) || (w_op == OpPop);
    w_store_m = (w_op == OpStm) || (w_op == OpPush);
    w_load_m  = (w_op == OpLdm) || (w_op == OpPop);
    w_cnt     = 4'($countones(w_in_list));
    w_list    = w_idle ? w_in_list : r_list;

    // Lowest set bit is the next register; it goes to the lowest remaining address.
    w_low = '0;
    w_bit = '0;
    for (int i = 8; i >= 0; i--) begin
      if (w_list[i]) begin
        w_low    = '0;
        w_low[i] = 1'b1;
        w_bit    = 4'(i);
      end
    end
    w_idx  = (w_bit == 4'd8) ? ((w_op == OpPush) ? 4'd14 : 4'd15) : w_bit;
    w_rest = w_list & ~w_low;
    w_last = (w_rest == '0);
    w_xfer = w_multi && (w_list != '0);

    w_step_n = AW'(w_cnt) * AW'(ADDR_STEP);
    w_addr0  = (w_op == OpPush) ? bus.base_addr - w_step_n : bus.base_addr;
    w_addr   = w_idle ? w_addr0 : r_addr;
    w_bwb    = w_idle ? ((w_op == OpPush) ? w_addr0 : bus.base_addr + w_step_n) : r_base_wb;
    w_sup    = w_idle ? ((w_op == OpLdm) && bus.reg_list[bus.rn_idx]) : r_sup;
  end

  always_comb begin
    w_state_d   = r_state;
    w_op_d      = r_op;
    w_opcode_d  = r_opcode;
    w_list_d    = r_list;
    w_addr_d    = r_addr;
    w_base_wb_d = r_base_wb;
    w_sup_d     = r_sup;
    w_wb_en_d   = 1'b0;
    w_wb_idx_d  = '0;
`ifdef LSM_POP_PC_EN
    w_pc_en_d   = 1'b0;
`endif
    bus.mem_write_en = 1'b0;
    bus.mem_opcode   = '0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.rf_rd_idx    = '0;
    bus.stall        = 1'b0;
    bus.done         = 1'b0;
    bus.base_wb_en   = 1'b0;
    bus.base_wb_data = '0;

    if ((w_op == OpStore) || (w_op == OpLoad)) begin
      bus.mem_write_en = (w_op == OpStore);
      bus.mem_opcode   = bus.opcode_in;
      bus.mem_addr     = bus.base_addr;
      bus.mem_wdata    = (w_op == OpStore) ? bus.store_data : '0;
      bus.done         = 1'b1;
      // Rd of a single load is tracked by the pipeline; wb_idx stays 0.
      w_wb_en_d        = (w_op == OpLoad);
    end else if (w_op == OpBad) begin
      bus.done = 1'b1;
    end else if (w_multi && !w_xfer) begin
      bus.done = 1'b1;
    end else if (w_xfer) begin
      bus.mem_write_en = w_store_m;
      bus.mem_opcode   = w_idle ? bus.opcode_in : r_opcode;
      bus.mem_addr     = w_addr;
      if (w_store_m) begin
        bus.rf_rd_idx = w_idx;
        bus.mem_wdata = bus.rf_rd_data;
      end
      bus.stall      = !w_last;
      bus.done       = w_last;
      bus.base_wb_en = w_last && !w_sup;
      if (w_last && !w_sup) bus.base_wb_data = w_bwb;
      if (w_load_m) begin
`ifdef LSM_POP_PC_EN
        if ((w_op == OpPop) && (w_bit == 4'd8)) begin
          w_pc_en_d = 1'b1;
        end else begin
          w_wb_en_d  = 1'b1;
          w_wb_idx_d = w_idx;
        end
`else
        w_wb_en_d  = 1'b1;
        w_wb_idx_d = w_idx;
`endif
      end
      w_list_d = w_rest;
      w_addr_d = w_addr + AW'(ADDR_STEP);
      if (w_idle) begin
        w_op_d      = w_op;
        w_opcode_d  = bus.opcode_in;
        w_base_wb_d = w_bwb;
        w_sup_d     = w_sup;
      end
      w_state_d = w_last ? StIdle : StMulti;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_op      <= OpNone;
      r_opcode  <= '0;
      r_list    <= '0;
      r_addr    <= '0;
      r_base_wb <= '0;
      r_sup     <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_idx  <= '0;
`ifdef LSM_POP_PC_EN
      r_pc_en   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_op      <= w_op_d;
      r_opcode  <= w_opcode_d;
      r_list    <= w_list_d;
      r_addr    <= w_addr_d;
      r_base_wb <= w_base_wb_d;
      r_sup     <= w_sup_d;
      r_wb_en   <= w_wb_en_d;
      r_wb_idx  <= w_wb_idx_d;
`ifdef LSM_POP_PC_EN
      r_pc_en   <= w_pc_en_d;
`endif
    end
  end

  // Read data arrives the cycle after the address, so it is forwarded combinationally.
  assign bus.wb_en   = r_wb_en;
  assign bus.wb_idx  = r_wb_idx;
  assign bus.wb_data = r_wb_en ? bus.mem_rdata : '0;
`ifdef LSM_POP_PC_EN
  assign bus.pc_load_en   = r_pc_en;
  assign bus.pc_load_data = r_pc_en ? bus.mem_rdata : '0;
`endif
endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer with a 1-cycle-latency word memory and register file model.
module tb_lsm_sequencer;
  localparam int KSt = 0, KLd = 1, KStm = 2, KLdm = 3, KPush = 4, KPop = 5, KBad = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsm_sequencer_if #(.AW(32)) bus ();

  lsm_sequencer #(.ADDR_STEP(1), .AW(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] rf      [16];
  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  logic [63:0] q_wr  [$];
  logic [35:0] q_wb  [$];
  logic [31:0] q_bwb [$];
  logic [31:0] q_pc  [$];

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic init_shadow();
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
  endtask

  assign bus.rf_rd_data = rf[bus.rf_rd_idx];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_write_en) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  // Scoreboard: every DUT-produced event must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_write_en) begin
        if (q_wr.size() == 0) check_eq("wr_unexpected", 32'(bus.mem_write_en), 32'd0);
        else begin
          logic [63:0] e;
          e = q_wr.pop_front();
          check_eq("wr_addr", bus.mem_addr, e[63:32]);
          check_eq("wr_data", bus.mem_wdata, e[31:0]);
        end
      end
      if (bus.wb_en) begin
        if (q_wb.size() == 0) check_eq("wb_unexpected", 32'(bus.wb_en), 32'd0);
        else begin
          logic [35:0] e;
          e = q_wb.pop_front();
          check_eq("wb_idx", 32'(bus.wb_idx), 32'(e[35:32]));
          check_eq("wb_data", bus.wb_data, e[31:0]);
        end
      end
      if (bus.base_wb_en) begin
        if (q_bwb.size() == 0) check_eq("base_wb_unexpected", 32'(bus.base_wb_en), 32'd0);
        else check_eq("base_wb_data", bus.base_wb_data, q_bwb.pop_front());
      end
`ifdef LSM_POP_PC_EN
      if (bus.pc_load_en) begin
        if (q_pc.size() == 0) check_eq("pc_unexpected", 32'(bus.pc_load_en), 32'd0);
        else check_eq("pc_load_data", bus.pc_load_data, q_pc.pop_front());
      end
`endif
    end
  end

  // Called at posedge+1; returns at posedge+1 after the op and its last writeback.
  task automatic run_op(input int kind, input logic [6:0] op, input logic [8:0] list,
                        input logic [2:0] rn, input logic [31:0] base, input logic [31:0] sd,
                        input bit hold);
    logic [8:0]  eff;
    logic [31:0] a, bwb;
    logic [3:0]  idx;
    int          n, ncyc;
    bit          sup;
    eff = '0;
    if (kind == KStm || kind == KLdm) eff = {1'b0, list[7:0]};
    if (kind == KPush) eff = list;
`ifdef LSM_POP_PC_EN
    if (kind == KPop) eff = list;
`else
    if (kind == KPop) eff = {1'b0, list[7:0]};
`endif
    n   = $countones(eff);
    a   = (kind == KPush) ? base - 32'(n) : base;
    bwb = (kind == KPush) ? a : base + 32'(n);
    sup = (kind == KLdm) && list[rn];
    for (int i = 0; i < 9; i++) begin
      if (eff[i]) begin
        idx = (i == 8) ? ((kind == KPush) ? 4'd14 : 4'd15) : 4'(i);
        if (kind == KStm || kind == KPush) begin
          q_wr.push_back({a, rf[idx]});
          exp_mem[a[7:0]] = rf[idx];
        end else if (i == 8) q_pc.push_back(exp_mem[a[7:0]]);
        else q_wb.push_back({idx, exp_mem[a[7:0]]});
        a = a + 32'd1;
      end
    end
    if (n > 0 && !sup && kind >= KStm && kind <= KPop) q_bwb.push_back(bwb);
    if (kind == KSt) begin
      q_wr.push_back({base, sd});
      exp_mem[base[7:0]] = sd;
    end
    if (kind == KLd) q_wb.push_back({4'd0, exp_mem[base[7:0]]});
    ncyc = (n == 0) ? 1 : n;

    bus.start      = 1'b1;
    bus.opcode_in  = op;
    bus.reg_list   = list;
    bus.rn_idx     = rn;
    bus.base_addr  = base;
    bus.store_data = sd;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check_eq("stall", 32'(bus.stall), 32'(k < ncyc - 1));
      check_eq("done", 32'(bus.done), 32'(k == ncyc - 1));
      @(posedge clk);
      #1;
      if (hold && (k + 1 < ncyc - 1)) begin
        bus.start      = 1'b1;
        bus.opcode_in  = 7'b0110000;
        bus.base_addr  = 32'd200;
        bus.store_data = 32'h0000_0BAD;
      end else bus.start = 1'b0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("q_wr_left", 32'(q_wr.size()), 32'd0);
    check_eq("q_wb_left", 32'(q_wb.size()), 32'd0);
    check_eq("q_bwb_left", 32'(q_bwb.size()), 32'd0);
    check_eq("q_pc_left", 32'(q_pc.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hC0DE_0000 + 32'(i) * 32'h101;
    init_shadow();
    bus.start      = 1'b0;
    bus.opcode_in  = '0;
    bus.reg_list   = '0;
    bus.rn_idx     = '0;
    bus.base_addr  = '0;
    bus.store_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_wr_en", 32'(bus.mem_write_en), 32'd0);
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_wb_en", 32'(bus.wb_en), 32'd0);
    check_eq("rst_addr", bus.mem_addr, 32'd0);
    @(posedge clk);
    #1;

    run_op(KSt,   7'b0110000, 9'h000, 3'd0, 32'd5,   32'hDEAD_BEEF, 1'b0);
    run_op(KLd,   7'b0110100, 9'h000, 3'd0, 32'd5,   32'h0,         1'b0);
    run_op(KPush, 7'b1011010, 9'h103, 3'd0, 32'd100, 32'h0,         1'b1);
    run_op(KPop,  7'b1011110, 9'h003, 3'd0, 32'd97,  32'h0,         1'b0);
    run_op(KLdm,  7'b1100101, 9'h00C, 3'd2, 32'd40,  32'h0,         1'b0);
    run_op(KStm,  7'b1100000, 9'h0A5, 3'd1, 32'd60,  32'h0,         1'b0);
    run_op(KLdm,  7'b1100100, 9'h0A5, 3'd1, 32'd60,  32'h0,         1'b0);
    run_op(KStm,  7'b1100000, 9'h000, 3'd0, 32'd10,  32'h0,         1'b0);
    run_op(KBad,  7'b0000000, 9'h0FF, 3'd0, 32'd10,  32'h0,         1'b0);
    run_op(KPop,  7'b1011110, 9'h110, 3'd0, 32'd60,  32'h0,         1'b0);
    run_op(KSt,   7'b0101000, 9'h000, 3'd0, 32'd200, 32'h1234_5678, 1'b0);
    run_op(KPush, 7'b1011010, 9'h008, 3'd0, 32'd0,   32'h0,         1'b0);
`ifdef LSM_POP_PC_EN
    run_op(KPop,  7'b1011110, 9'h100, 3'd0, 32'd50,  32'h0,         1'b0);
`endif

    // Reset in cycle 1 of an LDM aborts it and drops the pending writeback.
    bus.start     = 1'b1;
    bus.opcode_in = 7'b1100101;
    bus.reg_list  = 9'h00C;
    bus.rn_idx    = 3'd2;
    bus.base_addr = 32'd40;
    @(negedge clk);
    check_eq("ab_stall0", 32'(bus.stall), 32'd1);
    check_eq("ab_addr0", bus.mem_addr, 32'd40);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check_eq("ab_wb_en", 32'(bus.wb_en), 32'd0);
    check_eq("ab_wb_data", bus.wb_data, 32'd0);
    check_eq("ab_stall", 32'(bus.stall), 32'd0);
    check_eq("ab_done", 32'(bus.done), 32'd0);
    check_eq("ab_addr", bus.mem_addr, 32'd0);
    check_eq("ab_bwb", 32'(bus.base_wb_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_shadow();
    @(negedge clk);
    check_eq("ab_idle_stall", 32'(bus.stall), 32'd0);
    check_eq("ab_idle_wr", 32'(bus.mem_write_en), 32'd0);
    @(posedge clk);
    #1;
    run_op(KSt, 7'b0110000, 9'h000, 3'd0, 32'd7, 32'hCAFE_F00D, 1'b0);
    run_op(KLd, 7'b0110100, 9'h000, 3'd0, 32'd7, 32'h0,         1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
